plru_eviction_engine: RTL and testbench

- Tree pseudo-LRU eviction policy engine for one cache set.
- It is the responder side of the eviction-policy interface: it consumes the cache controller's hit/miss/allocate events and returns a one-hot eviction target with a ready flag.
- Victim selection walks the PLRU tree one level per clock. The target is held until the controller allocates.

---
 rtl/plru_eviction_engine.sv | 177 +++++++++++++++++
 tb/tb_plru_eviction_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/plru_eviction_engine.sv
// rtl/plru_eviction_engine.sv - tree pseudo-LRU eviction engine for one cache set (optional: PLRU_INVALID_FIRST_EN)
module plru_eviction_engine #(
  parameter int NUM_WAYS = 8,
  localparam int LEVELS = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_WAYS-1:0] hitWay,
  input  logic                hit,
  input  logic [NUM_WAYS-1:0] missWay,
  input  logic                miss,
  input  logic [NUM_WAYS-1:0] allocateWay,
  input  logic                allocate,
  output logic [NUM_WAYS-1:0] evictionTarget,
  output logic                evictionReady
);

  localparam int NODE_W = LEVELS + 1;
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [1:0] {IDLE, WALK, READY} state_t;

  state_t                state_q, state_d;
  logic [NUM_WAYS-2:0]   tree_q, tree_d, tree_hit;
  logic [NUM_WAYS-2:0]   snap_q, snap_d;
  logic [NODE_W-1:0]     node_q, node_d, node_nxt;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [NUM_WAYS-1:0]   target_q, target_d;
  logic                  ready_q, ready_d;
  logic                  snap_bit;
`ifdef PLRU_INVALID_FIRST_EN
  logic [NUM_WAYS-1:0]   valid_q, valid_d;
`endif

  // Isolate the lowest set bit so non-one-hot inputs behave deterministically.
  function automatic logic [NUM_WAYS-1:0] lsb_onehot(input logic [NUM_WAYS-1:0] v);
    return v & (~v + NUM_WAYS'(1));
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [LEVELS-1:0] oh2idx(input logic [NUM_WAYS-1:0] v);
    logic [NUM_WAYS-1:0] s;
    logic [LEVELS-1:0]   idx;
    logic                found;
    s     = v;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (s[0] && !found) begin
        idx   = LEVELS'(i);
        found = 1'b1;
      end
      s = s >> 1;
    end
    return idx;
  endfunction

  // Walk root-to-leaf for way w, pointing every node on the path away from it.
  function automatic logic [NUM_WAYS-2:0] touch(input logic [NUM_WAYS-2:0] t,
                                               input logic [LEVELS-1:0]   w);
    logic [NUM_WAYS-2:0] r;
    logic [LEVELS-1:0]   node;
    logic [LEVELS-1:0]   ws;
    logic                dir;
    r    = t;
    node = '0;
    ws   = w;
    for (int l = 0; l < LEVELS; l++) begin
      dir     = ws[LEVELS-1];
      r[node] = ~dir;
      node    = LEVELS'((32'(node) << 1) + 32'd1 + 32'(dir));
      ws      = ws << 1;
    end
    return r;
  endfunction

  assign snap_bit = snap_q[node_q[LEVELS-1:0]];
  assign node_nxt = {node_q[LEVELS-1:0], 1'b0} + NODE_W'(1) + NODE_W'(snap_bit);

  // Live tree update: hit first, then allocate so allocate wins on shared nodes.
  always_comb begin
    tree_hit = tree_q;
    if (hit && (|hitWay)) tree_hit = touch(tree_q, oh2idx(hitWay));
    tree_d = tree_hit;
    if (allocate && (|allocateWay)) tree_d = touch(tree_hit, oh2idx(allocateWay));
  end

`ifdef PLRU_INVALID_FIRST_EN
  // Mark allocated ways valid.
  always_comb begin
    valid_d = valid_q;
    if (allocate) valid_d = valid_q | lsb_onehot(allocateWay);
  end
`endif

  // Victim selection FSM: next state and registered outputs.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    node_d   = node_q;
    level_d  = level_q;
    target_d = target_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          if (|missWay) begin
            target_d = lsb_onehot(missWay);
            ready_d  = 1'b1;
            state_d  = READY;
`ifdef PLRU_INVALID_FIRST_EN
          end else if (!(&valid_q)) begin
            target_d = lsb_onehot(~valid_q);
            ready_d  = 1'b1;
            state_d  = READY;
`endif
          end else begin
            snap_d  = tree_d;
            node_d  = '0;
            level_d = '0;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        node_d  = node_nxt;
        level_d = level_q + LVL_W'(1);
        if (level_q == LVL_W'(LEVELS - 1)) begin
          target_d = NUM_WAYS'(1) << (node_nxt - NODE_W'(NUM_WAYS - 1));
          ready_d  = 1'b1;
          state_d  = READY;
        end
      end
      READY: begin
        if (allocate) begin
          target_d = '0;
          ready_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tree_q   <= '0;
      snap_q   <= '0;
      node_q   <= '0;
      level_q  <= '0;
      target_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tree_q   <= tree_d;
      snap_q   <= snap_d;
      node_q   <= node_d;
      level_q  <= level_d;
      target_q <= target_d;
      ready_q  <= ready_d;
    end
  end

`ifdef PLRU_INVALID_FIRST_EN
  // Valid bits with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end
`endif

  assign evictionTarget = target_q;
  assign evictionReady  = ready_q;

endmodule

// File: tb/tb_plru_eviction_engine.sv
// tb/tb_plru_eviction_engine.sv - directed self-checking bench for plru_eviction_engine
module tb_plru_eviction_engine;

  logic       clk;
  logic       reset_n;
  logic [7:0] hitWay;
  logic       hit;
  logic [7:0] missWay;
  logic       miss;
  logic [7:0] allocateWay;
  logic       allocate;
  logic [7:0] evictionTarget;
  logic       evictionReady;

  int checks = 0;
  int errors = 0;

  plru_eviction_engine #(.NUM_WAYS(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hitWay         (hitWay),
    .hit            (hit),
    .missWay        (missWay),
    .miss           (miss),
    .allocateWay    (allocateWay),
    .allocate       (allocate),
    .evictionTarget (evictionTarget),
    .evictionReady  (evictionReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss with no override; ready must appear on the 4th edge counting the sampling edge.
  task automatic miss_walk(input string tag, input logic [7:0] exp);
    miss = 1'b1; missWay = 8'h00;
    step();
    miss = 1'b0;
    step();
    step();
    check({tag, "_early"}, 32'(evictionReady), 32'd0);
    step();
    check({tag, "_ready"}, 32'(evictionReady), 32'd1);
    check({tag, "_target"}, 32'(evictionTarget), 32'(exp));
  endtask

  task automatic alloc(input string tag, input logic [7:0] way, input logic with_miss);
    allocate = 1'b1; allocateWay = way;
    miss = with_miss; missWay = with_miss ? 8'h80 : 8'h00;
    step();
    allocate = 1'b0; allocateWay = 8'h00; miss = 1'b0; missWay = 8'h00;
    check({tag, "_ready_clr"}, 32'(evictionReady), 32'd0);
    check({tag, "_target_clr"}, 32'(evictionTarget), 32'd0);
  endtask

  logic [7:0] seq [9];

  initial begin
    seq = '{8'h01, 8'h10, 8'h04, 8'h40, 8'h02, 8'h20, 8'h08, 8'h80, 8'h01};
    reset_n = 1'b0; hit = 1'b0; hitWay = '0; miss = 1'b0; missWay = '0;
    allocate = 1'b0; allocateWay = '0;
    #1;
    check("reset_ready", 32'(evictionReady), 32'd0);
    check("reset_target", 32'(evictionTarget), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();

`ifndef PLRU_INVALID_FIRST_EN
    miss_walk("first_miss", 8'h01);
    // Target holds and a miss while READY is ignored.
    miss = 1'b1; missWay = 8'h08;
    step(); step();
    miss = 1'b0; missWay = 8'h00;
    check("hold_ready", 32'(evictionReady), 32'd1);
    check("hold_target", 32'(evictionTarget), 32'h01);

    // Allocate loop over the full PLRU cycle; first allocate carries an ignored miss.
    for (int i = 1; i < 9; i++) begin
      alloc($sformatf("loop_alloc%0d", i), seq[i-1], (i == 1));
      if (i == 1) begin
        step();
        check("alloc_miss_ignored", 32'(evictionReady), 32'd0);
      end
      miss_walk($sformatf("loop_miss%0d", i), seq[i]);
    end
    alloc("cyc_alloc0", 8'h01, 1'b0);

    // Hit during WALK does not disturb the snapshot.
    miss = 1'b1; missWay = 8'h00;
    step();
    miss = 1'b0; hit = 1'b1; hitWay = 8'h10;
    step();
    hit = 1'b0; hitWay = 8'h00;
    step(); step();
    check("snap_ready", 32'(evictionReady), 32'd1);
    check("snap_target", 32'(evictionTarget), 32'h10);
    alloc("snap_alloc4", 8'h10, 1'b0);
    miss_walk("after4", 8'h04);
    alloc("after4_alloc", 8'h04, 1'b0);

    // missWay override, latency 1.
    miss = 1'b1; missWay = 8'h20;
    step();
    miss = 1'b0; missWay = 8'h00;
    check("ovr_ready", 32'(evictionReady), 32'd1);
    check("ovr_target", 32'(evictionTarget), 32'h20);
    alloc("ovr_alloc5", 8'h20, 1'b0);
    miss_walk("after5", 8'h02);
    alloc("after5_alloc", 8'h02, 1'b0);
    miss_walk("after1", 8'h40);

    // Asynchronous reset while READY.
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready_rdy", 32'(evictionReady), 32'd0);
    check("arst_ready_tgt", 32'(evictionTarget), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    alloc("pre_walk_alloc", 8'h01, 1'b0);

    // Asynchronous reset mid-WALK, then tree must be back to all zero.
    miss = 1'b1;
    step();
    miss = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("arst_walk_rdy", 32'(evictionReady), 32'd0);
    check("arst_walk_tgt", 32'(evictionTarget), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    miss_walk("post_reset", 8'h01);
`else
    // Invalid ways are chosen first with latency 1.
    miss = 1'b1; missWay = 8'h00;
    step();
    miss = 1'b0;
    check("inv0_ready", 32'(evictionReady), 32'd1);
    check("inv0_target", 32'(evictionTarget), 32'h01);
    alloc("inv0_alloc", 8'h01, 1'b0);
    miss = 1'b1;
    step();
    miss = 1'b0;
    check("inv1_ready", 32'(evictionReady), 32'd1);
    check("inv1_target", 32'(evictionTarget), 32'h02);
    alloc("inv1_alloc", 8'h02, 1'b0);
    miss = 1'b1; missWay = 8'h80;
    step();
    miss = 1'b0; missWay = 8'h00;
    check("inv_ovr_ready", 32'(evictionReady), 32'd1);
    check("inv_ovr_target", 32'(evictionTarget), 32'h80);
    alloc("inv_ovr_alloc", 8'h80, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
